// File: rtl/afifo_rd_engine_if.sv
// ============================================================================
//  Module      : afifo_rd_engine_if
//  Description : Bundle of the read-engine command, FIFO read-port, output
//                stream and status signals. The engine uses the slave view;
//                whoever drives it uses the master view.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface afifo_rd_engine_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) ();

  logic                  rd_req;
  logic [ADDR_WIDTH:0]   rd_len;
  logic                  rempty;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  rinc;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  busy;
  logic                  done;
  logic                  err;
  logic [15:0]           null_cnt;

  modport slave (
    input  rd_req, rd_len, rempty, rdata, out_ready,
    output rinc, out_data, out_valid, busy, done, err, null_cnt
  );

  modport master (
    output rd_req, rd_len, rempty, rdata, out_ready,
    input  rinc, out_data, out_valid, busy, done, err, null_cnt
  );

endinterface

`default_nettype wire

// File: rtl/afifo_rd_engine.sv
// ============================================================================
//  Module      : afifo_rd_engine
//  Description : Read-side burst controller for the async FIFO. Pops a
//                commanded number of words (show-ahead read port), presents
//                them on a registered valid/ready output, counts empty read
//                cycles and aborts the burst after a stall timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module afifo_rd_engine #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int TIMEOUT    = 1000
) (
  input  logic                   rclk_i,
  input  logic                   rrst_n_i,
  afifo_rd_engine_if.slave       bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam int LEN_W   = ADDR_WIDTH + 1;
  localparam int STALL_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [STALL_W-1:0] STALL_LIMIT = STALL_W'(TIMEOUT);

  logic [1:0]            state_q,     state_d;
  logic [LEN_W-1:0]      remaining_q, remaining_d;
  logic [STALL_W-1:0]    stall_q,     stall_d;
  logic [15:0]           null_cnt_q,  null_cnt_d;
  logic [DATA_WIDTH-1:0] out_data_q,  out_data_d;
  logic                  out_valid_q, out_valid_d;
  logic                  err_q,       err_d;

  logic w_slot_free;
  logic w_pop;
  logic w_accept;
  logic w_empty_cyc;

  // Pop strobe and per-cycle qualifiers; a pop only happens when the output
  // register can take the word on the same edge.
  always_comb begin
    w_slot_free = !out_valid_q || bus.out_ready;
    w_accept    = out_valid_q && bus.out_ready;
    w_pop       = (state_q == S_RUN) && !bus.rempty &&
                  (remaining_q != '0) && w_slot_free;
    w_empty_cyc = (state_q == S_RUN) && bus.rempty && w_slot_free;
  end

  // Next-state logic for the burst FSM, counters and output register.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    stall_d     = stall_q;
    null_cnt_d  = null_cnt_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    err_d       = err_q;

    // Pop takes priority so pop+accept on one edge keeps valid high.
    if (w_pop) begin
      out_data_d  = bus.rdata;
      out_valid_d = 1'b1;
    end else if (w_accept) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (bus.rd_req) begin
          err_d = 1'b0;
          if (bus.rd_len != '0) begin
            remaining_d = bus.rd_len;
            null_cnt_d  = 16'd0;
            stall_d     = '0;
            state_d     = S_RUN;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_RUN: begin
        if (w_pop) begin
          remaining_d = remaining_q - LEN_W'(1);
          stall_d     = '0;
          if (remaining_q == LEN_W'(1)) begin
            state_d = S_DRAIN;
          end
        end else if (w_empty_cyc) begin
          if (null_cnt_q != 16'hFFFF) begin
            null_cnt_d = null_cnt_q + 16'd1;
          end
          if (TIMEOUT != 0) begin
            stall_d = stall_q + STALL_W'(1);
            if ((stall_q + STALL_W'(1)) == STALL_LIMIT) begin
              err_d   = 1'b1;
              state_d = S_DRAIN;
            end
          end
        end
      end
      S_DRAIN: begin
        if (!out_valid_q || bus.out_ready) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers; reset leaves any unpopped words in the FIFO.
  always_ff @(posedge rclk_i or negedge rrst_n_i) begin
    if (!rrst_n_i) begin
      state_q     <= S_IDLE;
      remaining_q <= '0;
      stall_q     <= '0;
      null_cnt_q  <= 16'd0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      stall_q     <= stall_d;
      null_cnt_q  <= null_cnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
    end
  end

  assign bus.rinc      = w_pop;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done      = (state_q == S_DONE);
  assign bus.err       = err_q;
  assign bus.null_cnt  = null_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_afifo_rd_engine.sv
// ============================================================================
//  Module      : tb_afifo_rd_engine
//  Description : Directed testbench for afifo_rd_engine with a queue-based
//                show-ahead FIFO model on the read port.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_afifo_rd_engine;

  logic clk = 1'b0;
  logic rrst_n;

  always #5 clk = ~clk;

  afifo_rd_engine_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) bus ();

  afifo_rd_engine #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .TIMEOUT(8)) dut (
    .rclk_i   (clk),
    .rrst_n_i (rrst_n),
    .bus      (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  logic [31:0] fifo[$];
  logic [31:0] got[$];
  int pops, gap_at, gap_len, gap_left, cyc_n;
  int rinc_cnt, first_rinc, last_rinc, done_cnt, done_cyc, last_acc, viol;

  task automatic drive_fifo();
    bus.rempty = (gap_left > 0) || (fifo.size() == 0);
    bus.rdata  = (fifo.size() != 0) ? fifo[0] : 32'h0;
  endtask

  task automatic clear_stats();
    got.delete();
    pops = 0; gap_at = -1; gap_len = 0; gap_left = 0; cyc_n = 0;
    rinc_cnt = 0; first_rinc = -1; last_rinc = -1;
    done_cnt = 0; done_cyc = -1; last_acc = -1; viol = 0;
    drive_fifo();
  endtask

  // One clock cycle; entered and left at posedge+1 with inputs stable.
  task automatic cyc();
    logic p, a, d;
    logic [31:0] od;
    #3;
    p  = bus.rinc;
    a  = bus.out_valid && bus.out_ready;
    od = bus.out_data;
    d  = bus.done;
    if (p && bus.rempty) viol++;
    if (p && bus.out_valid && !bus.out_ready) viol++;
    if (p) begin
      rinc_cnt++;
      if (first_rinc < 0) first_rinc = cyc_n;
      last_rinc = cyc_n;
    end
    if (d) begin done_cnt++; done_cyc = cyc_n; end
    if (a) last_acc = cyc_n;
    @(posedge clk); #1;
    if (gap_left > 0) gap_left--;
    if (p && fifo.size() != 0) begin
      void'(fifo.pop_front());
      pops++;
      if (pops == gap_at) gap_left = gap_len;
    end
    if (a) got.push_back(od);
    drive_fifo();
    cyc_n++;
  endtask

  task automatic start(input int len);
    bus.rd_req = 1'b1;
    bus.rd_len = 5'(len);
    cyc();
    bus.rd_req = 1'b0;
  endtask

  task automatic test_reset();
    fifo.push_back(32'h1111_1111);
    drive_fifo();
    bus.rd_req = 1'b1; bus.rd_len = 5'd3; bus.out_ready = 1'b1;
    rrst_n = 1'b1;
    #2 rrst_n = 1'b0;
    #1;
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", bus.out_valid); end
    n_cmp++; if (bus.out_data !== 32'h0) begin n_fail++; $display("FAIL rst_data: got %h want 0", bus.out_data); end
    n_cmp++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b want 0", bus.done); end
    n_cmp++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b want 0", bus.err); end
    n_cmp++; if (bus.null_cnt !== 16'h0) begin n_fail++; $display("FAIL rst_null: got %h want 0", bus.null_cnt); end
    n_cmp++; if (bus.rinc !== 1'b0) begin n_fail++; $display("FAIL rst_rinc: got %b want 0", bus.rinc); end
    @(posedge clk); #1;
    n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
    bus.rd_req = 1'b0;
    rrst_n = 1'b1;
    fifo.delete();
    clear_stats();
    @(posedge clk); #1;
  endtask

  task automatic test_burst4();
    for (int i = 0; i < 4; i++) fifo.push_back(32'hA0A0_0000 + i);
    clear_stats();
    bus.out_ready = 1'b1;
    start(4);
    for (int i = 0; i < 30 && done_cnt == 0; i++) cyc();
    n_cmp++; if (done_cnt !== 1) begin n_fail++; $display("FAIL t1_done_cnt: got %0d want 1", done_cnt); end
    n_cmp++; if (got.size() !== 4) begin n_fail++; $display("FAIL t1_count: got %0d want 4", got.size()); end
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      n_cmp++; if (got[i] !== 32'hA0A0_0000 + i) begin n_fail++; $display("FAIL t1_word[%0d]: got %h want %h", i, got[i], 32'hA0A0_0000 + i); end
    end
    n_cmp++; if (rinc_cnt !== 4) begin n_fail++; $display("FAIL t1_rinc_cnt: got %0d want 4", rinc_cnt); end
    n_cmp++; if (first_rinc !== 1 || last_rinc !== 4) begin n_fail++; $display("FAIL t1_rinc_span: got %0d..%0d want 1..4", first_rinc, last_rinc); end
    n_cmp++; if (last_acc !== 5) begin n_fail++; $display("FAIL t1_last_accept: got %0d want 5", last_acc); end
    n_cmp++; if (done_cyc !== 6) begin n_fail++; $display("FAIL t1_done_cycle: got %0d want 6", done_cyc); end
    n_cmp++; if (bus.null_cnt !== 16'd0) begin n_fail++; $display("FAIL t1_null: got %0d want 0", bus.null_cnt); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL t1_busy_after: got %b want 0", bus.busy); end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 6; i++) fifo.push_back(32'hC0C0_0000 + i);
    clear_stats();
    bus.out_ready = 1'b1;
    start(6);
    for (int i = 0; i < 60 && done_cnt == 0; i++) begin
      bus.out_ready = ((cyc_n % 2) == 0);
      cyc();
    end
    bus.out_ready = 1'b1;
    n_cmp++; if (done_cnt !== 1) begin n_fail++; $display("FAIL t2_done_cnt: got %0d want 1", done_cnt); end
    n_cmp++; if (got.size() !== 6) begin n_fail++; $display("FAIL t2_count: got %0d want 6", got.size()); end
    for (int i = 0; i < 6 && i < got.size(); i++) begin
      n_cmp++; if (got[i] !== 32'hC0C0_0000 + i) begin n_fail++; $display("FAIL t2_word[%0d]: got %h want %h", i, got[i], 32'hC0C0_0000 + i); end
    end
    n_cmp++; if (viol !== 0) begin n_fail++; $display("FAIL t2_rinc_protocol: got %0d violations want 0", viol); end
    n_cmp++; if (rinc_cnt !== 6) begin n_fail++; $display("FAIL t2_rinc_cnt: got %0d want 6", rinc_cnt); end
  endtask

  task automatic test_gap();
    for (int i = 0; i < 4; i++) fifo.push_back(32'hD0D0_0000 + i);
    clear_stats();
    gap_at = 2; gap_len = 5;
    bus.out_ready = 1'b1;
    start(4);
    for (int i = 0; i < 40 && done_cnt == 0; i++) cyc();
    n_cmp++; if (done_cnt !== 1) begin n_fail++; $display("FAIL t3_done_cnt: got %0d want 1", done_cnt); end
    n_cmp++; if (got.size() !== 4) begin n_fail++; $display("FAIL t3_count: got %0d want 4", got.size()); end
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      n_cmp++; if (got[i] !== 32'hD0D0_0000 + i) begin n_fail++; $display("FAIL t3_word[%0d]: got %h want %h", i, got[i], 32'hD0D0_0000 + i); end
    end
    n_cmp++; if (viol !== 0) begin n_fail++; $display("FAIL t3_rinc_in_gap: got %0d violations want 0", viol); end
    n_cmp++; if (bus.null_cnt !== 16'd5) begin n_fail++; $display("FAIL t3_null: got %0d want 5", bus.null_cnt); end
    n_cmp++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL t3_err: got %b want 0", bus.err); end
    n_cmp++; if (done_cyc !== 11) begin n_fail++; $display("FAIL t3_done_cycle: got %0d want 11", done_cyc); end
  endtask

  task automatic test_timeout();
    fifo.delete();
    clear_stats();
    bus.out_ready = 1'b1;
    start(2);
    for (int i = 0; i < 40 && done_cnt == 0; i++) cyc();
    n_cmp++; if (done_cnt !== 1) begin n_fail++; $display("FAIL t4_done_cnt: got %0d want 1", done_cnt); end
    n_cmp++; if (rinc_cnt !== 0) begin n_fail++; $display("FAIL t4_rinc_cnt: got %0d want 0", rinc_cnt); end
    n_cmp++; if (done_cyc !== 10) begin n_fail++; $display("FAIL t4_done_cycle: got %0d want 10", done_cyc); end
    n_cmp++; if (bus.err !== 1'b1) begin n_fail++; $display("FAIL t4_err: got %b want 1", bus.err); end
    n_cmp++; if (bus.null_cnt !== 16'd8) begin n_fail++; $display("FAIL t4_null: got %0d want 8", bus.null_cnt); end
  endtask

  task automatic test_zero_len();
    fifo.push_back(32'hE0E0_0000);
    fifo.push_back(32'hE0E0_0001);
    clear_stats();
    n_cmp++; if (bus.err !== 1'b1) begin n_fail++; $display("FAIL t5_err_held: got %b want 1", bus.err); end
    start(0);
    n_cmp++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL t5_err_clear: got %b want 0", bus.err); end
    for (int i = 0; i < 10 && done_cnt == 0; i++) cyc();
    n_cmp++; if (done_cyc !== 1) begin n_fail++; $display("FAIL t5_done_cycle: got %0d want 1", done_cyc); end
    n_cmp++; if (rinc_cnt !== 0) begin n_fail++; $display("FAIL t5_rinc_cnt: got %0d want 0", rinc_cnt); end
    n_cmp++; if (fifo.size() !== 2) begin n_fail++; $display("FAIL t5_fifo_left: got %0d want 2", fifo.size()); end
  endtask

  task automatic test_busy_req();
    fifo.delete();
    for (int i = 0; i < 5; i++) fifo.push_back(32'hF0F0_0000 + i);
    clear_stats();
    bus.out_ready = 1'b1;
    start(3);
    for (int i = 0; i < 12; i++) begin
      bus.rd_req = (cyc_n >= 1 && cyc_n <= 3);
      bus.rd_len = 5'd5;
      cyc();
    end
    bus.rd_req = 1'b0;
    n_cmp++; if (done_cnt !== 1) begin n_fail++; $display("FAIL t5b_done_cnt: got %0d want 1", done_cnt); end
    n_cmp++; if (rinc_cnt !== 3) begin n_fail++; $display("FAIL t5b_rinc_cnt: got %0d want 3", rinc_cnt); end
    n_cmp++; if (got.size() !== 3) begin n_fail++; $display("FAIL t5b_count: got %0d want 3", got.size()); end
    for (int i = 0; i < 3 && i < got.size(); i++) begin
      n_cmp++; if (got[i] !== 32'hF0F0_0000 + i) begin n_fail++; $display("FAIL t5b_word[%0d]: got %h want %h", i, got[i], 32'hF0F0_0000 + i); end
    end
    n_cmp++; if (fifo.size() !== 2) begin n_fail++; $display("FAIL t5b_fifo_left: got %0d want 2", fifo.size()); end
    fifo.delete();
    drive_fifo();
  endtask

  task automatic test_reset_midburst();
    for (int i = 0; i < 6; i++) fifo.push_back(32'hB0B0_0000 + i);
    clear_stats();
    bus.out_ready = 1'b1;
    start(6);
    for (int i = 0; i < 10 && pops < 2; i++) cyc();
    n_cmp++; if (pops !== 2) begin n_fail++; $display("FAIL t6_pre_pops: got %0d want 2", pops); end
    rrst_n = 1'b0;
    #1;
    n_cmp++; if (bus.rinc !== 1'b0) begin n_fail++; $display("FAIL t6_rinc: got %b want 0", bus.rinc); end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL t6_valid: got %b want 0", bus.out_valid); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL t6_busy: got %b want 0", bus.busy); end
    n_cmp++; if (fifo.size() !== 4 || bus.rempty !== 1'b0) begin n_fail++; $display("FAIL t6_fifo_left: got %0d/%b want 4/0", fifo.size(), bus.rempty); end
    #1 rrst_n = 1'b1;
    @(posedge clk); #1;
    clear_stats();
    start(4);
    for (int i = 0; i < 30 && done_cnt == 0; i++) cyc();
    n_cmp++; if (got.size() !== 4) begin n_fail++; $display("FAIL t6_count: got %0d want 4", got.size()); end
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      n_cmp++; if (got[i] !== 32'hB0B0_0002 + i) begin n_fail++; $display("FAIL t6_word[%0d]: got %h want %h", i, got[i], 32'hB0B0_0002 + i); end
    end
    n_cmp++; if (done_cnt !== 1) begin n_fail++; $display("FAIL t6_done_cnt: got %0d want 1", done_cnt); end
  endtask

  initial begin
    bus.rd_req = 1'b0; bus.rd_len = 5'd0; bus.out_ready = 1'b0;
    bus.rempty = 1'b1; bus.rdata = 32'h0;
    fifo.delete();
    clear_stats();
    test_reset();
    test_burst4();
    test_backpressure();
    test_gap();
    test_timeout();
    test_zero_len();
    test_busy_req();
    test_reset_midburst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
